window_line_buffer: RTL and testbench

- Parametrised successor to the fixed 3-line buffer: streams raster-order pixels and presents a full KxK sliding window per accepted pixel.
- Sits between the pixel source and the systolic-array conv front end.
- Adds over the previous generation: generic K, a real valid/ready handshake with backpressure, per-window validity from row and column position, and a frame-start resync.

---
 rtl/window_line_buffer_if.sv | 29 ++
 rtl/window_line_buffer.sv | 75 +++++++
 tb/tb_window_line_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/window_line_buffer_if.sv
// window_line_buffer_if: pixel-in / window-out handshake bundle for window_line_buffer.
// Status fields are present only with WINDOW_LINE_BUFFER_STATUS_EN.
interface window_line_buffer_if #(
    parameter int DATA_W = 8,
    parameter int K = 3,
    parameter int COL_W = 11
);
    logic                    valid_in;
    logic [DATA_W-1:0]       din;
    logic                    sof_in;
    logic                    ready_in;
    logic                    win_valid;
    logic [K*K*DATA_W-1:0]   win_data;
    logic                    win_ready;
`ifdef WINDOW_LINE_BUFFER_STATUS_EN
    logic [COL_W-1:0]        win_row;
    logic [COL_W-1:0]        win_col;
    logic                    win_last;
    modport master(output valid_in, din, sof_in, win_ready,
                   input ready_in, win_valid, win_data, win_row, win_col, win_last);
    modport slave(input valid_in, din, sof_in, win_ready,
                  output ready_in, win_valid, win_data, win_row, win_col, win_last);
`else
    modport master(output valid_in, din, sof_in, win_ready,
                   input ready_in, win_valid, win_data);
    modport slave(input valid_in, din, sof_in, win_ready,
                  output ready_in, win_valid, win_data);
`endif
endinterface

// File: rtl/window_line_buffer.sv
// window_line_buffer: raster pixels in, KxK sliding window out, valid/ready with backpressure.
// Optional win_row/win_col/win_last outputs under WINDOW_LINE_BUFFER_STATUS_EN.
module window_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W = 482,
    parameter int IMG_H = 256,
    parameter int K = 3,
    parameter int COL_W = 11
) (
    input logic clk,
    input logic rst_n,
    window_line_buffer_if.slave bus
);
    localparam int AW = $clog2(IMG_W);
    localparam int RW = K * DATA_W;
    localparam logic [COL_W-1:0] C_MAX = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] R_MAX = COL_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] K_MIN = COL_W'(K - 1);

    logic [COL_W-1:0] c_cnt, r_cnt, pc, pr;
    logic acc, qual, win_valid;
    logic [AW-1:0] addr;
    logic [DATA_W-1:0] tap [K];
    logic [K-1:0][RW-1:0] win;

    assign bus.ready_in = !win_valid || bus.win_ready;
    assign acc = bus.valid_in && bus.ready_in;
    // sof relabels the accepted pixel as (0,0) before anything else uses its position
    assign pc = bus.sof_in ? '0 : c_cnt;
    assign pr = bus.sof_in ? '0 : r_cnt;
    assign addr = pc[AW-1:0];
    assign qual = (pr >= K_MIN) && (pc >= K_MIN);
    assign tap[K-1] = bus.din;
    assign bus.win_valid = win_valid;
    assign bus.win_data = win;

    // line m holds row r-(K-1-m); on accept each line takes the one below it
    for (genvar m = 0; m < K - 1; m++) begin : g_line
        logic [DATA_W-1:0] mem [IMG_W];
        assign tap[m] = mem[addr];
        always_ff @(posedge clk)
            if (acc) mem[addr] <= tap[m+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cnt <= '0;
            r_cnt <= '0;
            win_valid <= 1'b0;
            win <= '0;
        end else begin
            win_valid <= acc ? qual : (win_valid && !bus.win_ready);
            if (acc) begin
                c_cnt <= (pc == C_MAX) ? '0 : pc + COL_W'(1);
                r_cnt <= (pc == C_MAX) ? ((pr == R_MAX) ? '0 : pr + COL_W'(1)) : pr;
                for (int i = 0; i < K; i++)
                    win[i] <= {tap[i], win[i][RW-1:DATA_W]};
            end
        end
    end

`ifdef WINDOW_LINE_BUFFER_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.win_row <= '0;
            bus.win_col <= '0;
            bus.win_last <= 1'b0;
        end else if (acc) begin
            bus.win_row <= pr;
            bus.win_col <= pc;
            bus.win_last <= (pr == R_MAX) && (pc == C_MAX);
        end
    end
`endif
endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: randomized scoreboard bench for window_line_buffer (K=3, 5x4 frames).
// Stimulus pushes expected windows from a frame-array model; a monitor pops and compares.
module tb_window_line_buffer;
    localparam int DW = 8, IW = 5, IH = 4, KK = 3, CW = 11;
    localparam int WW = KK * KK * DW;

    typedef struct {
        logic [WW-1:0] data;
        int row;
        int col;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_line_buffer_if #(.DATA_W(DW), .K(KK), .COL_W(CW)) bus();
    window_line_buffer #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .COL_W(CW))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t q[$];
    logic [WW-1:0] seen[$];
    logic [WW-1:0] ref1[$];
    int checks = 0, errors = 0;
    int mr = 0, mc = 0;
    logic [DW-1:0] img [IH][IW];
    int gap_pct = 0, wr_mode = 0, wr_idx = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // expected window = the KxK block of the current frame ending at the accepted pixel
    task automatic model_accept(input logic [DW-1:0] px, input bit sof);
        exp_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = px;
        if (mr >= KK - 1 && mc >= KK - 1) begin
            e.data = '0;
            for (int i = 0; i < KK; i++)
                for (int j = 0; j < KK; j++)
                    e.data[(i*KK+j)*DW +: DW] = img[mr-KK+1+i][mc-KK+1+j];
            e.row = mr;
            e.col = mc;
            e.last = (mr == IH - 1) && (mc == IW - 1);
            q.push_back(e);
        end
        mc++;
        if (mc == IW) begin
            mc = 0;
            mr = (mr == IH - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic send(input logic [DW-1:0] px, input bit sof);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            @(posedge clk);
            #2;
            bus.win_ready = (wr_mode == 0) ? 1'b1 :
                            (wr_mode == 1) ? (wr_idx % 4 == 0 || wr_idx % 4 == 3) :
                            1'($urandom_range(1));
            wr_idx++;
            bus.valid_in = ($urandom_range(99) >= gap_pct);
            bus.din = px;
            bus.sof_in = sof;
            #1;
            if (bus.win_valid && !bus.win_ready) chk("ready_in_stall", WW'(bus.ready_in), WW'(0));
            if (bus.valid_in && bus.ready_in) begin
                model_accept(px, sof);
                done = 1;
            end else if (++guard > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
                done = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            bus.valid_in = 1'b0;
            bus.sof_in = 1'b0;
            bus.win_ready = 1'b1;
        end
    endtask

    task automatic frame(input int off, input bit sof_first);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                send(DW'(r * 16 + c + off), sof_first && r == 0 && c == 0);
    endtask

    task automatic finish_scn(input string name, input int n);
        idle(6);
        chk({name, "_count"}, WW'(seen.size()), WW'(n));
        chk({name, "_drain"}, WW'(q.size()), WW'(0));
    endtask

    initial begin
        logic pv;
        logic [WW-1:0] pd;
        exp_t e;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_win_valid", WW'(bus.win_valid), WW'(0));
                chk("rst_win_data", bus.win_data, WW'(0));
                chk("rst_ready_in", WW'(bus.ready_in), WW'(1));
`ifdef WINDOW_LINE_BUFFER_STATUS_EN
                chk("rst_status", WW'({bus.win_row, bus.win_col, bus.win_last}), WW'(0));
`endif
            end else if (pv && !bus.win_ready) begin
                chk("hold_valid", WW'(bus.win_valid), WW'(1));
                chk("hold_data", bus.win_data, pd);
            end else if (bus.win_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got %h expected none", bus.win_data);
                end else begin
                    e = q.pop_front();
                    chk("win_data", bus.win_data, e.data);
`ifdef WINDOW_LINE_BUFFER_STATUS_EN
                    chk("win_row", WW'(bus.win_row), WW'(e.row));
                    chk("win_col", WW'(bus.win_col), WW'(e.col));
                    chk("win_last", WW'(bus.win_last), WW'(e.last));
`endif
                end
                seen.push_back(bus.win_data);
            end
            pv = bus.win_valid && rst_n;
            pd = bus.win_data;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        bus.valid_in = 1'b0;
        bus.din = '0;
        bus.sof_in = 1'b0;
        bus.win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        seen.delete();
        frame(0, 0);
        finish_scn("full", 6);
        chk("full_first", seen[0], {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00});
        chk("full_last", seen[5], {8'h34, 8'h33, 8'h32, 8'h24, 8'h23, 8'h22, 8'h14, 8'h13, 8'h12});
        ref1 = seen;

        seen.delete();
        wr_mode = 1;
        frame(0, 0);
        finish_scn("stall", 6);
        for (int i = 0; i < 6; i++) chk("stall_seq", seen[i], ref1[i]);

        seen.delete();
        wr_mode = 2;
        gap_pct = 50;
        frame(0, 0);
        finish_scn("gaps", 6);
        for (int i = 0; i < 6; i++) chk("gaps_seq", seen[i], ref1[i]);

        seen.delete();
        wr_mode = 0;
        gap_pct = 0;
        frame(0, 0);
        frame(8'h80, 0);
        finish_scn("two_frames", 12);
        chk("frame2_first", seen[6], {8'hA2, 8'hA1, 8'hA0, 8'h92, 8'h91, 8'h90, 8'h82, 8'h81, 8'h80});

        seen.delete();
        wr_mode = 2;
        gap_pct = 30;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW; c++) send(DW'(r * 16 + c), 0);
        send(8'h20, 0);
        frame(8'h40, 1);
        finish_scn("sof", 6);
        chk("sof_first", seen[0], {8'h62, 8'h61, 8'h60, 8'h52, 8'h51, 8'h50, 8'h42, 8'h41, 8'h40});

        wr_mode = 0;
        gap_pct = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < IW; c++)
                if (r < 2 || c <= 3) send(DW'(r * 16 + c), 0);
        @(posedge clk);
        #2;
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mr = 0;
        mc = 0;
        seen.delete();
        frame(0, 0);
        finish_scn("after_reset", 6);
        for (int i = 0; i < 6; i++) chk("reset_seq", seen[i], ref1[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
